// File: rtl/alu_pkg.sv
// Shared ALU definitions: the default datapath width, the opcode encodings and the flag bundle.
package alu_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_ADDS = 4'b0010,
        OP_SUBS = 4'b0011,
        OP_CMP  = 4'b0100,
        OP_LSL  = 4'b0101,
        OP_LSR  = 4'b0110,
        OP_AND  = 4'b0111,
        OP_OR   = 4'b1000,
        OP_XOR  = 4'b1001,
        OP_MVN  = 4'b1010
    } opcode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_adder.sv
// Shared add/subtract path: sum = a + (sub ? ~b : b) + sub.
// The carry output means "no borrow" when sub is set.
module alu_adder #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    logic [DATA_W-1:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};

endmodule

// File: rtl/alu_core.sv
// Registered ALU with NZCV flags and a single-cycle result.
// Defining ALU_SHIFT_EN compiles in the LSL/LSR opcodes; without it those codes change nothing.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_en,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [3:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              overflow_flag,
    output logic              negative_flag
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] res_q, res_d, sum;
    flags_t            flg_q, flg_d;
    logic              sub, carry, add_v, sub_v;

    assign sub = (alu_control == OP_SUB) || (alu_control == OP_SUBS) || (alu_control == OP_CMP);

    alu_adder #(.DATA_W(DATA_W)) u_adder (
        .a     (operand_a),
        .b     (operand_b),
        .sub   (sub),
        .sum   (sum),
        .carry (carry)
    );

    assign add_v = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
    assign sub_v = (operand_a[MSB] != operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);

`ifdef ALU_SHIFT_EN
    localparam int SH_W = $clog2(DATA_W);
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] shl, shr;
    logic              shl_out, shr_out;

    assign shamt   = operand_b[SH_W-1:0];
    assign shl     = operand_a << shamt;
    assign shr     = operand_a >> shamt;
    // Last bit out of LSL is a[DATA_W - n]; of LSR it is a[n - 1]; only used when n != 0.
    assign shl_out = operand_a[DATA_W - 1 - (32'(shamt) - 32'd1)];
    assign shr_out = operand_a[32'(shamt) - 32'd1];
`endif

    always_comb begin
        res_d = res_q;
        flg_d = flg_q;
        case (alu_control)
            OP_ADD, OP_SUB: res_d = sum;
            OP_ADDS: begin
                res_d = sum;
                flg_d = '{n: sum[MSB], z: (sum == '0), c: carry, v: add_v};
            end
            OP_SUBS: begin
                res_d = sum;
                flg_d = '{n: sum[MSB], z: (sum == '0), c: carry, v: sub_v};
            end
            OP_CMP: flg_d = '{n: sum[MSB], z: (sum == '0), c: carry, v: sub_v};
            OP_AND: res_d = operand_a & operand_b;
            OP_OR:  res_d = operand_a | operand_b;
            OP_XOR: res_d = operand_a ^ operand_b;
            OP_MVN: res_d = ~operand_a;
`ifdef ALU_SHIFT_EN
            OP_LSL: begin
                res_d = shl;
                if (shamt != '0) flg_d.c = shl_out;
            end
            OP_LSR: begin
                res_d = shr;
                if (shamt != '0) flg_d.c = shr_out;
            end
`endif
            default: ;
        endcase
        // Logical and shift ops share the N/Z update from their result.
        case (alu_control)
            OP_AND, OP_OR, OP_XOR, OP_MVN
`ifdef ALU_SHIFT_EN
            , OP_LSL, OP_LSR
`endif
            : begin
                flg_d.n = res_d[MSB];
                flg_d.z = (res_d == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            flg_q <= '0;
        end else if (alu_en) begin
            res_q <= res_d;
            flg_q <= flg_d;
        end
    end

    assign result        = res_q;
    assign negative_flag = flg_q.n;
    assign zero_flag     = flg_q.z;
    assign carry_flag    = flg_q.c;
    assign overflow_flag = flg_q.v;

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core; flags are compared as {N,Z,C,V}.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_en;
    logic [31:0] operand_a, operand_b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        zero_flag, carry_flag, overflow_flag, negative_flag;

    int checks = 0;
    int passed = 0;

    alu_core #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_en        (alu_en),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .alu_control   (alu_control),
        .result        (result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .negative_flag (negative_flag)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic en, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst         = r;
        alu_en      = en;
        alu_control = op;
        operand_a   = a;
        operand_b   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp_res, input logic [3:0] exp_nzcv);
        logic [3:0] nzcv;
        nzcv = {negative_flag, zero_flag, carry_flag, overflow_flag};
        checks++;
        assert (result === exp_res) passed++;
        else $error("FAIL %s result: observed %h expected %h", tag, result, exp_res);
        checks++;
        assert (nzcv === exp_nzcv) passed++;
        else $error("FAIL %s nzcv: observed %b expected %b", tag, nzcv, exp_nzcv);
    endtask

    initial begin
        rst = 1'b1; alu_en = 1'b0; alu_control = 4'h0; operand_a = '0; operand_b = '0;
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        check("reset", 32'h0, 4'b0000);

        step(1'b0, 1'b1, 4'b0010, 32'd10, 32'd20);
        check("adds_10_20", 32'd30, 4'b0000);
        step(1'b0, 1'b1, 4'b0011, 32'hFFFF_FFF6, 32'd5);
        check("subs_neg", 32'hFFFF_FFF1, 4'b1010);
        step(1'b0, 1'b1, 4'b0000, 32'd10, 32'd20);
        check("add_flags_hold", 32'd30, 4'b1010);
        step(1'b0, 1'b1, 4'b0100, 32'd10, 32'd20);
        check("cmp_10_20", 32'd30, 4'b1000);

        step(1'b0, 1'b1, 4'b0111, 32'hC, 32'hA);
        check("and", 32'h8, 4'b0000);
        step(1'b0, 1'b1, 4'b1000, 32'hC, 32'hA);
        check("or", 32'hE, 4'b0000);
        step(1'b0, 1'b1, 4'b1001, 32'hC, 32'hA);
        check("xor", 32'h6, 4'b0000);
        step(1'b0, 1'b1, 4'b1010, 32'hC, 32'h1234_5678);
        check("mvn", 32'hFFFF_FFF3, 4'b1000);

        step(1'b0, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1);
        check("adds_ovf", 32'h8000_0000, 4'b1001);
        step(1'b0, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        check("adds_wrap", 32'h0, 4'b0110);
        step(1'b0, 1'b1, 4'b0001, 32'd5, 32'd3);
        check("sub_flags_hold", 32'd2, 4'b0110);

        step(1'b0, 1'b1, 4'b1011, 32'hDEAD_BEEF, 32'h1);
        check("undef_1011", 32'd2, 4'b0110);
        step(1'b0, 1'b1, 4'b1111, 32'h0, 32'h0);
        check("undef_1111", 32'd2, 4'b0110);
`ifdef ALU_SHIFT_EN
        step(1'b0, 1'b1, 4'b0101, 32'h8000_0001, 32'd1);
        check("lsl_1", 32'h2, 4'b0010);
        step(1'b0, 1'b1, 4'b0110, 32'h0000_0003, 32'd1);
        check("lsr_1", 32'h1, 4'b0010);
        step(1'b0, 1'b1, 4'b0110, 32'h8000_0000, 32'd0);
        check("lsr_0", 32'h8000_0000, 4'b1010);
        step(1'b0, 1'b1, 4'b0001, 32'd5, 32'd3);
        step(1'b0, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        step(1'b0, 1'b1, 4'b0001, 32'd5, 32'd3);
        check("resync", 32'd2, 4'b0110);
`else
        step(1'b0, 1'b1, 4'b0101, 32'h8000_0001, 32'd1);
        check("lsl_disabled", 32'd2, 4'b0110);
        step(1'b0, 1'b1, 4'b0110, 32'h8000_0001, 32'd1);
        check("lsr_disabled", 32'd2, 4'b0110);
`endif

        step(1'b0, 1'b1, 4'b0011, 32'h8000_0000, 32'd1);
        check("subs_ovf", 32'h7FFF_FFFF, 4'b0011);
        step(1'b0, 1'b1, 4'b0111, 32'hF0, 32'h0F);
        check("and_zero", 32'h0, 4'b0111);

        step(1'b0, 1'b0, 4'b0010, 32'd100, 32'd200);
        check("en_low_hold", 32'h0, 4'b0111);
        step(1'b0, 1'b0, 4'b1010, 32'h0, 32'h0);
        check("en_low_hold2", 32'h0, 4'b0111);

        step(1'b0, 1'b1, 4'b0010, 32'd1, 32'd2);
        check("adds_pre_rst", 32'd3, 4'b0000);
        step(1'b1, 1'b1, 4'b0011, 32'd1, 32'd2);
        check("rst_over_en", 32'h0, 4'b0000);
        step(1'b0, 1'b0, 4'b0011, 32'd1, 32'd2);
        check("post_rst_idle", 32'h0, 4'b0000);
        step(1'b0, 1'b1, 4'b0010, 32'd10, 32'd20);
        check("post_rst_adds", 32'd30, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
